control_unit: RTL
=================

# control_unit

Multicycle controller for the 16-bit CPU. It consumes the 5-bit opcode and the status register from the datapath. It drives every datapath mux select and register write enable, plus memory write. It sequences FETCH/DECODE/EXEC/MEM/WB per instruction, stalls on a memory-ready handshake, and keeps a retired-instruction counter for debug.

## Interface
- WORD_SIZE, 16, status/counter width
- clk  in  1  clock, all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- opcode  in  5  instruction class, from the instruction register (stable from DECODE on)
- status_reg  in  WORD_SIZE  flags: bit0 Z, bit1 N, bit2 C, bit3 V
- mem_ready  in  1  memory completes the current access this cycle
- ALU_in2_mux  out  2  0 reg_buff2, 1 imm3, 2 imm2, 3 zero
- data_in_mux  out  2  0 ALU_out_buff, 1 memory_in, 2 imm2, 3 PC
- PC_mux  out  2  0 PC+1, 1 imm1, 2 reg_buff1
- memory_addr_mux  out  2  0 PC, 1 reg_buff1, 2 imm2, 3 ALU_out_buff
- mem_out_mux  out  1  1 reg_buff1, 0 reg_buff2
- reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write, reg_write, PC_write, IR_write, mem_write  out  1 each  write enables
- halted  out  1  high in HALT state
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode
- retired  out  WORD_SIZE  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from state, opcode, status_reg and mem_ready.
- Every select defaults to 0 and every enable defaults to 0 unless listed below.
- FETCH: memory_addr_mux=0. IR_write=1, PC_write=1 and PC_mux=0 only when mem_ready=1. Go to DECODE on mem_ready, else stay in FETCH.
- DECODE: reg_buff1_write=1, reg_buff2_write=1. Next state by opcode:
  - 00000 NOP: retire, go to FETCH.
  - 00001 ALU R-R; 00010 ALU R-imm3; 01110 CMP: go to EXEC.
  - 00011 LI: go to WB.
  - 00100 LD; 00101 ST; 00110 LDA; 00111 STA: go to MEM.
  - 01000 JMP; 01001 JR; 01010 BZ; 01011 BNZ; 01100 BN; 01101 CALL: go to EXEC.
  - 11111 HALT: go to HALT.
  - Any other opcode: illegal=1, treated as NOP.
- EXEC, by opcode:
  - ALU R-R: ALU_in2_mux=0, ALU_out_write=1, status_reg_write=1, go to WB.
  - ALU R-imm3: same as R-R with ALU_in2_mux=1.
  - CMP: ALU_in2_mux=0, status_reg_write=1, retire, go to FETCH.
  - JMP: PC_mux=1, PC_write=1.
  - JR: PC_mux=2, PC_write=1.
  - BZ / BNZ / BN: PC_mux=1, PC_write = Z / !Z / N, using status_reg as sampled this cycle.
  - CALL: data_in_mux=3, reg_write=1, PC_mux=1, PC_write=1. The register file captures the already-incremented PC on the same edge.
  - All jumps, branches and CALL retire and go to FETCH.
- MEM, by opcode:
  - LD: memory_addr_mux=1, data_in_mux=1.
  - LDA: memory_addr_mux=2, data_in_mux=1.
  - For LD and LDA, reg_write = mem_ready.
  - ST: memory_addr_mux=1, mem_out_mux=0, mem_write=1 for the whole state.
  - STA: memory_addr_mux=2, mem_out_mux=1, mem_write=1 for the whole state.
  - Stay in MEM until mem_ready, then retire and go to FETCH.
- WB:
  - ALU ops: data_in_mux=0, reg_write=1.
  - LI: data_in_mux=2, reg_write=1.
  - Retire, go to FETCH.
- HALT: all enables 0, halted=1. Leave only via rst.
- Retire: retired increments by 1 on the clock edge that leaves the instruction's final state. It wraps 0xFFFF to 0x0000. HALT and illegal opcodes do not retire.

## Timing
- rst asserted: state=FETCH, retired=0 immediately. All enables are forced to 0 while rst is high, and halted=0, illegal=0.
- First fetch occurs on the first posedge after rst deasserts.
- Cycle counts with mem_ready held at 1:
  - NOP: 2.
  - LI, CMP, LD, ST, LDA, STA, JMP, JR, branches, CALL: 3.
  - ALU R-R and ALU R-imm3: 4.
- Each cycle mem_ready is low in FETCH or MEM adds exactly one cycle. No enable other than mem_write fires during a stall cycle.
- A branch reads status_reg in EXEC. A CMP or ALU op immediately before it is already visible, because status_reg_write landed earlier.
- rst mid-instruction (including mid-stall or mid-store) aborts the instruction at once. mem_write drops asynchronously and no retire occurs.
- HALT with mem_ready toggling: stays in HALT, outputs unchanged.

## Test plan
- Reset, then NOP, mem_ready=1: IR_write and PC_write high at cycle 0, DECODE at cycle 1, back in FETCH at cycle 2, retired=1.
- ALU R-R: EXEC asserts ALU_out_write and status_reg_write with ALU_in2_mux=0; WB asserts reg_write with data_in_mux=0; 4 cycles total, retired+1.
- BZ with Z=1, then with Z=0: EXEC has PC_write=1, PC_mux=1 in the first case and PC_write=0 in the second; both take 3 cycles and retire.
- ST with mem_ready low for 3 cycles in MEM: mem_write=1 for 4 cycles, reg_write never set, state moves to FETCH after the ready cycle.
- Opcode 10000, then 11111: illegal pulses for one cycle with no retire, then halted=1 and stays 1 for 20 cycles. Asserting rst returns to FETCH with retired=0.
- Preload retired to 0xFFFF via 65535 NOPs (or force it): the next NOP gives retired=0x0000. Assert rst during an LD stall: reg_write is never seen and state is FETCH.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle controller for the 16-bit CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module control_unit #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           opcode,
  input  logic [WORD_SIZE-1:0] status_reg,
  input  logic                 mem_ready,
  output logic [1:0]           ALU_in2_mux,
  output logic [1:0]           data_in_mux,
  output logic [1:0]           PC_mux,
  output logic [1:0]           memory_addr_mux,
  output logic                 mem_out_mux,
  output logic                 reg_buff1_write,
  output logic                 reg_buff2_write,
  output logic                 status_reg_write,
  output logic                 ALU_out_write,
  output logic                 reg_write,
  output logic                 PC_write,
  output logic                 IR_write,
  output logic                 mem_write,
  output logic                 halted,
  output logic                 illegal,
  output logic [WORD_SIZE-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_RR   = 5'b00001;
  localparam logic [4:0] OP_RI   = 5'b00010;
  localparam logic [4:0] OP_LI   = 5'b00011;
  localparam logic [4:0] OP_LD   = 5'b00100;
  localparam logic [4:0] OP_ST   = 5'b00101;
  localparam logic [4:0] OP_LDA  = 5'b00110;
  localparam logic [4:0] OP_STA  = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_JR   = 5'b01001;
  localparam logic [4:0] OP_BZ   = 5'b01010;
  localparam logic [4:0] OP_BNZ  = 5'b01011;
  localparam logic [4:0] OP_BN   = 5'b01100;
  localparam logic [4:0] OP_CALL = 5'b01101;
  localparam logic [4:0] OP_CMP  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t state;
  state_t state_nxt;
  logic   retire;
  logic   retire_c;
  logic [WORD_SIZE-1:0] retired_q;

  logic op_nop, op_rr, op_ri, op_li;
  logic op_ld, op_st, op_lda, op_sta;
  logic op_jmp, op_jr, op_bz, op_bnz;
  logic op_bn, op_call, op_cmp, op_halt;

  assign op_nop  = (opcode == OP_NOP);
  assign op_rr   = (opcode == OP_RR);
  assign op_ri   = (opcode == OP_RI);
  assign op_li   = (opcode == OP_LI);
  assign op_ld   = (opcode == OP_LD);
  assign op_st   = (opcode == OP_ST);
  assign op_lda  = (opcode == OP_LDA);
  assign op_sta  = (opcode == OP_STA);
  assign op_jmp  = (opcode == OP_JMP);
  assign op_jr   = (opcode == OP_JR);
  assign op_bz   = (opcode == OP_BZ);
  assign op_bnz  = (opcode == OP_BNZ);
  assign op_bn   = (opcode == OP_BN);
  assign op_call = (opcode == OP_CALL);
  assign op_cmp  = (opcode == OP_CMP);
  assign op_halt = (opcode == OP_HALT);

  logic flag_z;
  logic flag_n;
  assign flag_z = status_reg[0];
  assign flag_n = status_reg[1];

  logic rb1_c, rb2_c, sw_c, aw_c;
  logic rw_c, pcw_c, irw_c, mw_c;
  logic hlt_c, ill_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire)
        retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;

  always_comb begin
    state_nxt       = state;
    ALU_in2_mux     = 2'd0;
    data_in_mux     = 2'd0;
    PC_mux          = 2'd0;
    memory_addr_mux = 2'd0;
    mem_out_mux     = 1'b0;
    rb1_c           = 1'b0;
    rb2_c           = 1'b0;
    sw_c            = 1'b0;
    aw_c            = 1'b0;
    rw_c            = 1'b0;
    pcw_c           = 1'b0;
    irw_c           = 1'b0;
    mw_c            = 1'b0;
    hlt_c           = 1'b0;
    ill_c           = 1'b0;
    retire_c        = 1'b0;

    unique case (state)
      S_FETCH: begin
        if (mem_ready) begin
          irw_c     = 1'b1;
          pcw_c     = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        rb1_c = 1'b1;
        rb2_c = 1'b1;
        unique case (1'b1)
          op_nop: begin
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end
          op_rr, op_ri, op_cmp,
          op_jmp, op_jr, op_bz,
          op_bnz, op_bn, op_call:
            state_nxt = S_EXEC;
          op_li:
            state_nxt = S_WB;
          op_ld, op_st, op_lda, op_sta:
            state_nxt = S_MEM;
          op_halt:
            state_nxt = S_HALT;
          default: begin
            ill_c     = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        unique case (1'b1)
          op_rr, op_ri: begin
            ALU_in2_mux = op_ri ? 2'd1 : 2'd0;
            aw_c        = 1'b1;
            sw_c        = 1'b1;
            state_nxt   = S_WB;
          end
          op_cmp: begin
            sw_c     = 1'b1;
            retire_c = 1'b1;
          end
          op_jmp: begin
            PC_mux   = 2'd1;
            pcw_c    = 1'b1;
            retire_c = 1'b1;
          end
          op_jr: begin
            PC_mux   = 2'd2;
            pcw_c    = 1'b1;
            retire_c = 1'b1;
          end
          op_bz, op_bnz, op_bn: begin
            PC_mux   = 2'd1;
            pcw_c    = (op_bz & flag_z) |
                       (op_bnz & ~flag_z) |
                       (op_bn & flag_n);
            retire_c = 1'b1;
          end
          op_call: begin
            data_in_mux = 2'd3;
            rw_c        = 1'b1;
            PC_mux      = 2'd1;
            pcw_c       = 1'b1;
            retire_c    = 1'b1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        unique case (1'b1)
          op_ld, op_lda: begin
            memory_addr_mux = op_lda ? 2'd2 : 2'd1;
            data_in_mux     = 2'd1;
            rw_c            = mem_ready;
          end
          op_st, op_sta: begin
            memory_addr_mux = op_sta ? 2'd2 : 2'd1;
            mem_out_mux     = op_sta;
            mw_c            = 1'b1;
          end
          default: ;
        endcase
        if (mem_ready) begin
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_WB: begin
        data_in_mux = op_li ? 2'd2 : 2'd0;
        rw_c        = 1'b1;
        retire_c    = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_HALT: begin
        hlt_c = 1'b1;
      end

      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset masks every strobe immediately, ahead of the async state clear.
  assign reg_buff1_write  = rb1_c & ~rst;
  assign reg_buff2_write  = rb2_c & ~rst;
  assign status_reg_write = sw_c  & ~rst;
  assign ALU_out_write    = aw_c  & ~rst;
  assign reg_write        = rw_c  & ~rst;
  assign PC_write         = pcw_c & ~rst;
  assign IR_write         = irw_c & ~rst;
  assign mem_write        = mw_c  & ~rst;
  assign halted           = hlt_c & ~rst;
  assign illegal          = ill_c & ~rst;
  assign retire           = retire_c & ~rst;

endmodule
